// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: 8N1 UART byte transmitter with registered outputs and a level idle flag.
module uart_tx_serializer #(
  parameter int CLOCKS_PER_BIT = 868,
  parameter int STOP_BITS      = 1,
  parameter int COUNTER_SIZE   = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       is_tx_ready,
  input  logic [7:0] tx_data,
  output logic       tx_line,
  output logic       is_tx_done
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;
  localparam logic [COUNTER_SIZE-1:0] BIT_LAST  = COUNTER_SIZE'(CLOCKS_PER_BIT - 1);
  localparam logic [COUNTER_SIZE-1:0] STOP_LAST = COUNTER_SIZE'(STOP_BITS * CLOCKS_PER_BIT - 1);
  logic [1:0]              state;
  logic [COUNTER_SIZE-1:0] baud_cnt;
  logic [2:0]              bit_idx;
  logic [7:0]              data_reg;
  logic                    bit_end;
  logic                    stop_end;
  logic [2:0]              nxt_idx;
  always_comb begin
    bit_end  = baud_cnt == BIT_LAST;
    stop_end = baud_cnt == STOP_LAST;
    nxt_idx  = bit_idx + 3'd1;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      tx_line    <= 1'b1;
      is_tx_done <= 1'b1;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      data_reg   <= '0;
    end else begin
      case (state)
        IDLE: if (is_tx_ready) begin
          data_reg   <= tx_data;
          tx_line    <= 1'b0;
          is_tx_done <= 1'b0;
          baud_cnt   <= '0;
          bit_idx    <= '0;
          state      <= START;
        end
        START: if (bit_end) begin
          baud_cnt <= '0;
          tx_line  <= data_reg[0];
          state    <= DATA;
        end else baud_cnt <= baud_cnt + 1'b1;
        DATA: if (bit_end) begin
          baud_cnt <= '0;
          bit_idx  <= nxt_idx;
          tx_line  <= bit_idx == 3'd7 ? 1'b1 : data_reg[nxt_idx];
          state    <= bit_idx == 3'd7 ? STOP : DATA;
        end else baud_cnt <= baud_cnt + 1'b1;
        default: if (stop_end) begin
          baud_cnt   <= '0;
          is_tx_done <= 1'b1;
          state      <= IDLE;
        end else baud_cnt <= baud_cnt + 1'b1;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: scoreboard bench; a per-cycle line monitor checks every frame against queued bytes.
module tb_uart_tx_serializer;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic rdy0 = 1'b0, rdy1 = 1'b0;
  logic [7:0] d0 = 8'h00, d1 = 8'h00;
  logic line0, done0, line1, done1;
  int tests = 0, fails = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  bit in_frame[2];
  int cyc[2];
  logic [7:0] exp_byte[2];

  always #5 CLK = ~CLK;

  uart_tx_serializer #(.CLOCKS_PER_BIT(4), .STOP_BITS(1), .COUNTER_SIZE(16)) dut0 (
    .CLK(CLK), .RST(RST), .is_tx_ready(rdy0), .tx_data(d0), .tx_line(line0), .is_tx_done(done0));
  uart_tx_serializer #(.CLOCKS_PER_BIT(4), .STOP_BITS(2), .COUNTER_SIZE(16)) dut1 (
    .CLK(CLK), .RST(RST), .is_tx_ready(rdy1), .tx_data(d1), .tx_line(line1), .is_tx_done(done1));

  task automatic mon(input int ch, input logic ln, input logic dn, input int len);
    logic [7:0] b;
    logic ex;
    int k;
    if (RST) begin
      in_frame[ch] = 1'b0;
      return;
    end
    if (!in_frame[ch] && ln === 1'b0) begin
      in_frame[ch] = 1'b1;
      cyc[ch] = 0;
      tests++;
      if (ch == 0 && q0.size() > 0) exp_byte[ch] = q0.pop_front();
      else if (ch == 1 && q1.size() > 0) exp_byte[ch] = q1.pop_front();
      else begin
        fails++;
        exp_byte[ch] = 8'h00;
        $display("FAIL unexpected_frame ch%0d: frame started, required none", ch);
      end
    end
    tests++;
    if (!in_frame[ch]) begin
      if (ln !== 1'b1 || dn !== 1'b1) begin
        fails++;
        $display("FAIL idle ch%0d: line=%b done=%b, required 1 1", ch, ln, dn);
      end
    end else if (cyc[ch] < len) begin
      b = exp_byte[ch];
      k = cyc[ch] / 4;
      ex = (k == 0) ? 1'b0 : (k <= 8) ? b[k-1] : 1'b1;
      if (ln !== ex || dn !== 1'b0) begin
        fails++;
        $display("FAIL frame_bit ch%0d byte=%h cyc=%0d: line=%b done=%b, required %b 0", ch, b, cyc[ch], ln, dn, ex);
      end
      cyc[ch]++;
    end else begin
      if (ln !== 1'b1 || dn !== 1'b1) begin
        fails++;
        $display("FAIL frame_end ch%0d: line=%b done=%b, required 1 1", ch, ln, dn);
      end
      in_frame[ch] = 1'b0;
    end
  endtask

  always @(negedge CLK) begin
    mon(0, line0, done0, 40);
    mon(1, line1, done1, 44);
  end

  task automatic strobe(input int ch, input logic [7:0] b);
    if (ch == 0) begin
      d0 = b; rdy0 = 1'b1; q0.push_back(b);
    end else begin
      d1 = b; rdy1 = 1'b1; q1.push_back(b);
    end
    @(posedge CLK); #1;
    rdy0 = 1'b0; rdy1 = 1'b0;
  endtask

  task automatic count_low(input int ch, output int n);
    n = 0;
    while (((ch == 0) ? done0 : done1) === 1'b0 && n < 200) begin
      n++;
      @(posedge CLK); #1;
    end
  endtask

  task automatic check_n(input string name, input int n, input int req);
    tests++;
    if (n != req) begin
      fails++;
      $display("FAIL %s: done low %0d cycles, required %0d", name, n, req);
    end
  endtask

  task automatic test_reset;
    int n;
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    tests++;
    if ({line0, done0, line1, done1} !== 4'b1111) begin
      fails++;
      $display("FAIL reset_state: %b, required 1111", {line0, done0, line1, done1});
    end
    repeat (2) @(posedge CLK); #1;
    n = 0;
  endtask

  task automatic test_frame_a5;
    int n;
    strobe(0, 8'hA5);
    count_low(0, n);
    check_n("frame_a5", n, 40);
    repeat (3) @(posedge CLK); #1;
  endtask

  task automatic test_back_to_back;
    int n;
    strobe(0, 8'h00);
    count_low(0, n);
    check_n("b2b_first", n, 40);
    strobe(0, 8'hFF);
    tests++;
    if (done0 !== 1'b0) begin
      fails++;
      $display("FAIL b2b_accept: done=%b, required 0", done0);
    end
    count_low(0, n);
    check_n("b2b_second", n, 40);
    repeat (3) @(posedge CLK); #1;
  endtask

  task automatic test_ignore_midframe;
    int n;
    strobe(0, 8'h81);
    for (int i = 0; i < 39; i++) begin
      rdy0 = (i % 7 == 3);
      d0 = 8'h3C;
      @(posedge CLK); #1;
    end
    rdy0 = 1'b0;
    count_low(0, n);
    check_n("midframe_tail", n, 1);
    for (int i = 0; i < 12; i++) begin
      @(posedge CLK); #1;
      tests++;
      if (done0 !== 1'b1) begin
        fails++;
        $display("FAIL midframe_no_requeue cyc %0d: done=%b, required 1", i, done0);
      end
    end
  endtask

  task automatic test_reset_midframe;
    int n;
    strobe(0, 8'h55);
    repeat (21) @(posedge CLK);
    #1 RST = 1'b1;
    @(posedge CLK);
    #1 RST = 1'b0;
    tests++;
    if (line0 !== 1'b1 || done0 !== 1'b1) begin
      fails++;
      $display("FAIL reset_midframe: line=%b done=%b, required 1 1", line0, done0);
    end
    repeat (2) @(posedge CLK); #1;
    strobe(0, 8'h0F);
    count_low(0, n);
    check_n("after_reset_frame", n, 40);
    repeat (3) @(posedge CLK); #1;
  endtask

  task automatic test_two_stop;
    int n;
    strobe(1, 8'hC3);
    count_low(1, n);
    check_n("two_stop", n, 44);
    repeat (3) @(posedge CLK); #1;
  endtask

  task automatic test_chunk;
    logic [7:0] chunk[3];
    int n;
    chunk[0] = 8'h11; chunk[1] = 8'h22; chunk[2] = 8'h33;
    for (int i = 0; i < 3; i++) begin
      n = 0;
      while (done0 !== 1'b1 && n < 200) begin
        n++;
        @(posedge CLK); #1;
      end
      tests++;
      if (done0 !== 1'b1) begin
        fails++;
        $display("FAIL chunk_wait byte %0d: done=%b, required 1", i, done0);
      end
      strobe(0, chunk[i]);
    end
    count_low(0, n);
    check_n("chunk_last", n, 40);
    repeat (3) @(posedge CLK); #1;
    tests++;
    if (done0 !== 1'b1 || q0.size() != 0) begin
      fails++;
      $display("FAIL chunk_idle: done=%b pending=%0d, required 1 0", done0, q0.size());
    end
  endtask

  initial begin
    test_reset();
    test_frame_a5();
    test_back_to_back();
    test_ignore_midframe();
    test_reset_midframe();
    test_two_stop();
    test_chunk();
    tests++;
    if (q0.size() != 0 || q1.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: pending %0d/%0d, required 0/0", q0.size(), q1.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1);
  end
endmodule
